gate_sweep_checker: RTL and testbench
=====================================

Name: gate_sweep_checker

Overview:
- Parametrised exhaustive truth-table tester for the team's switch-level gate cells (not/nor/or and successors).
- Drives every input combination onto an external gate-under-test and waits a programmable settle time per vector.
- Samples the gate output, compares it against a built-in golden function selected by mode, and reports the error count and the first failing vector.
- Replaces the open-coded for-loop/delay benches with a synthesizable, reusable sequencer.

Parameters:
- WIDTH, 2, number of gate inputs; legal range 1..8.
- SETTLE, 2, clock cycles each vector is held before its response is sampled; minimum 1.

Ports:
- clk  input  1  single clock; all state changes on the rising edge.
- rst  input  1  synchronous, active-high reset.
- start  input  1  begins a sweep when high in IDLE; ignored otherwise.
- mode  input  3  golden function, latched on an accepted start. 0 OR-reduce, 1 NOR, 2 AND, 3 NAND, 4 XOR, 5 XNOR, 6 NOT of stim[0], 7 BUF of stim[0].
- stim  output  WIDTH  vector driven to the gate-under-test inputs.
- resp  input  1  gate-under-test output.
- busy  output  1  high while a sweep is in progress.
- done  output  1  one-cycle pulse at the end of a sweep.
- pass  output  1  high when the last completed sweep had zero mismatches.
- err_count  output  WIDTH+1  mismatch count for the current or last sweep.
- fail_valid  output  1  high once any mismatch has been recorded in the current or last sweep.
- fail_vec  output  WIDTH  first mismatching stim value.

Behaviour:
- Reset values (next edge with rst=1, from any state): state IDLE; stim=0; busy, done, pass and fail_valid =0; err_count=0; fail_vec=0.
- rst mid-sweep aborts the sweep immediately. No done pulse is produced.
- FSM states:
  - IDLE: start=1 moves to APPLY. On the same edge: mode latched, stim=0, err_count=0, fail_valid=0, fail_vec=0, pass=0, settle counter=0.
  - APPLY: stim held constant. The settle counter increments each cycle. On the edge ending the SETTLE-th cycle of the vector, resp is compared with golden(stim).
    - If more vectors remain, stim increments, the counter clears, and the state stays APPLY.
    - After vector 2^WIDTH-1, go to DONE.
  - DONE: done=1 and busy=0 for exactly one cycle; pass=(err_count==0). Then IDLE.
- busy is high in every APPLY cycle only.
- Timing: with start sampled high at edge T0, vector v is driven in cycles T0+1+v*SETTLE through T0+(v+1)*SETTLE. done is high in cycle T0+2^WIDTH*SETTLE+1.
- In DONE and IDLE, stim holds its last value, 2^WIDTH-1.
- Comparison is a 4-state mismatch: resp of X or Z counts as an error. This catches floating switch-level nets.
- On a mismatch, err_count increments. It cannot exceed 2^WIDTH, so WIDTH+1 bits never wrap.
- The first mismatch of a sweep sets fail_valid=1 and fail_vec=stim. Later mismatches do not change fail_vec.
- Golden for modes 6/7 uses stim[0] only. Upper bits are still swept, so every vector is checked.
- start while busy or in DONE is ignored. start held high continuously re-triggers from IDLE, one cycle after done.
- mode changes during a sweep have no effect, because the latched copy is used.
- pass, err_count, fail_valid and fail_vec hold from DONE until the next accepted start or reset.

Test Plan:
1. WIDTH=2, SETTLE=2, mode=0, resp from a correct OR model. Required:
   - stim 00,01,10,11, each held 2 cycles.
   - busy high 8 cycles; done in cycle T0+9.
   - pass=1, err_count=0, fail_valid=0.
2. WIDTH=2, SETTLE=2, mode=1 (NOR), resp tied 0. Required: mismatch only at 00; err_count=1, fail_vec=00, fail_valid=1, pass=0.
3. mode=2 (AND), resp driven by an OR model. Required: mismatches at 01 and 10; err_count=2, fail_vec=01, pass=0.
4. mode=4 (XOR), resp left undriven (Z). Required: err_count=4, fail_vec=00, pass=0.
5. rst=1 for one cycle while stim=10. Required: next cycle busy=0, stim=00, err_count=0, no done. A following start sweeps from 00 to completion. A second start pulse during that sweep is ignored, and done pulses once.
6. WIDTH=3, SETTLE=1, mode=3 (NAND), correct model. Required: 8 vectors, one cycle each; done in cycle T0+9; pass=1.

Source files
------------

// File: rtl/gate_sweep_checker.sv
// Exhaustive truth-table sweeper for switch-level gate cells.
// Steps stim through every input combination, holds each vector for SETTLE
// cycles, then compares the gate response against a golden function picked
// by mode. Reports the mismatch count and the first failing vector.
//
// state | meaning
// ------+--------------------------------------------------------------
// IDLE  | waiting for start; results of the last sweep are held
// APPLY | driving stim and waiting out the settle time, then comparing
// DONE  | one-cycle completion pulse, then back to IDLE
module gate_sweep_checker #(
    parameter int WIDTH  = 2,
    parameter int SETTLE = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [2:0]       mode,
    output logic [WIDTH-1:0] stim,
    input  logic             resp,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [WIDTH:0]   err_count,
    output logic             fail_valid,
    output logic [WIDTH-1:0] fail_vec
);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] APPLY = 2'd1;
    localparam logic [1:0] DONE  = 2'd2;

    localparam int CW = (SETTLE > 1) ? $clog2(SETTLE) : 1;
    localparam logic [CW-1:0]    LAST_CNT = CW'(SETTLE - 1);
    localparam logic [WIDTH-1:0] LAST_VEC = {WIDTH{1'b1}};
    localparam logic [WIDTH:0]   ONE      = {{WIDTH{1'b0}}, 1'b1};

    logic [1:0]    state;
    logic [2:0]    mode_q;
    logic [CW-1:0] cnt;
    logic          golden;
    logic          mism;

    // Golden response for the current vector under the latched mode
    always_comb begin
        golden = 1'b0;
        case (mode_q)
            3'd0: golden = |stim;
            3'd1: golden = ~|stim;
            3'd2: golden = &stim;
            3'd3: golden = ~&stim;
            3'd4: golden = ^stim;
            3'd5: golden = ~^stim;
            3'd6: golden = ~stim[0];
            default: golden = stim[0];
        endcase
    end

    // Case inequality so a floating (X/Z) response is flagged as an error
    assign mism = (resp !== golden);

    assign busy = (state == APPLY);
    assign done = (state == DONE);

    // Sweep sequencer, settle counter and result capture
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            mode_q     <= 3'd0;
            cnt        <= '0;
            stim       <= '0;
            pass       <= 1'b0;
            err_count  <= '0;
            fail_valid <= 1'b0;
            fail_vec   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        state      <= APPLY;
                        mode_q     <= mode;
                        cnt        <= '0;
                        stim       <= '0;
                        pass       <= 1'b0;
                        err_count  <= '0;
                        fail_valid <= 1'b0;
                        fail_vec   <= '0;
                    end
                end
                APPLY: begin
                    if (cnt == LAST_CNT) begin
                        cnt <= '0;
                        if (mism) begin
                            err_count <= err_count + ONE;
                            if (!fail_valid) begin
                                fail_valid <= 1'b1;
                                fail_vec   <= stim;
                            end
                        end
                        if (stim == LAST_VEC) begin
                            state <= DONE;
                            // Include the final vector's verdict so pass is valid alongside done
                            pass  <= (err_count == '0) && !mism;
                        end else begin
                            stim <= stim + 1'b1;
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_gate_sweep_checker.sv
// Directed bench for gate_sweep_checker: a vector table of modes and response
// models on a 2-input instance, plus reset-abort and 3-input sequences.
module tb_gate_sweep_checker;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst;
    logic       start2, start3;
    logic [2:0] mode2, mode3;
    logic [1:0] stim2;
    logic [2:0] stim3;
    logic       resp2, resp3;
    logic       busy2, done2, pass2, fv2;
    logic       busy3, done3, pass3, fv3;
    logic [2:0] err2;
    logic [3:0] err3;
    logic [1:0] fvec2;
    logic [2:0] fvec3;
    int         rsel2;

    gate_sweep_checker #(.WIDTH(2), .SETTLE(2)) dut2 (
        .clk(clk), .rst(rst), .start(start2), .mode(mode2), .stim(stim2),
        .resp(resp2), .busy(busy2), .done(done2), .pass(pass2),
        .err_count(err2), .fail_valid(fv2), .fail_vec(fvec2)
    );

    gate_sweep_checker #(.WIDTH(3), .SETTLE(1)) dut3 (
        .clk(clk), .rst(rst), .start(start3), .mode(mode3), .stim(stim3),
        .resp(resp3), .busy(busy3), .done(done3), .pass(pass3),
        .err_count(err3), .fail_valid(fv3), .fail_vec(fvec3)
    );

    // Gate-under-test models. rsel 2 is a gate that never gives the XOR value,
    // standing in for a floating output on a two-state simulator.
    always_comb begin
        resp2 = 1'b0;
        case (rsel2)
            0: resp2 = |stim2;
            1: resp2 = 1'b0;
            2: resp2 = ~(^stim2);
            default: resp2 = |stim2;
        endcase
    end
    assign resp3 = ~&stim3;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d", name, act, exp);
        end
    endtask

    typedef struct {
        logic [2:0] mode;
        int         rsel;
        int         exp_err;
        int         exp_fv;
        int         exp_fvec;
        int         exp_pass;
    } vec_t;

    vec_t tbl[8];

    // One sweep on the 2-input instance; mode is scrambled after start to
    // confirm the latched copy is used, and an optional extra start is
    // pulsed at cycle extra_k.
    task automatic run2(input logic [2:0] m, input int extra_k,
                        output int done_k, output int busy_n,
                        output int stim_bad, output int done_n);
        @(negedge clk);
        mode2  = m;
        start2 = 1'b1;
        @(posedge clk);
        done_k = 0; busy_n = 0; stim_bad = 0; done_n = 0;
        for (int k = 1; k <= 14; k++) begin
            @(negedge clk);
            start2 = (k == extra_k);
            mode2  = m + 3'd3;
            if (busy2) begin
                busy_n++;
                if (k > 8 || stim2 !== 2'((k - 1) / 2)) stim_bad++;
            end
            if (done2) begin
                done_n++;
                if (done_k == 0) done_k = k;
            end
        end
        start2 = 1'b0;
    endtask

    int dk, bn, sb, dn;
    int waited;

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1);
    end

    initial begin
        rst = 1'b1; start2 = 1'b0; start3 = 1'b0;
        mode2 = 3'd0; mode3 = 3'd0; rsel2 = 0;

        tbl[0] = '{3'd0, 0, 0, 0, 0, 1};  // OR, correct
        tbl[1] = '{3'd1, 1, 1, 1, 0, 0};  // NOR, tied 0
        tbl[2] = '{3'd2, 0, 2, 1, 1, 0};  // AND vs OR gate
        tbl[3] = '{3'd4, 2, 4, 1, 0, 0};  // XOR, never right
        tbl[4] = '{3'd5, 0, 3, 1, 0, 0};  // XNOR vs OR gate
        tbl[5] = '{3'd6, 1, 2, 1, 0, 0};  // NOT stim[0], tied 0
        tbl[6] = '{3'd7, 0, 1, 1, 2, 0};  // BUF stim[0] vs OR gate
        tbl[7] = '{3'd3, 1, 3, 1, 0, 0};  // NAND, tied 0

        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        chk("rst_busy", busy2, 0);
        chk("rst_done", done2, 0);
        chk("rst_pass", pass2, 0);
        chk("rst_err", err2, 0);
        chk("rst_fv", fv2, 0);
        chk("rst_fvec", fvec2, 0);
        chk("rst_stim", stim2, 0);

        for (int i = 0; i < 8; i++) begin
            rsel2 = tbl[i].rsel;
            run2(tbl[i].mode, 0, dk, bn, sb, dn);
            chk($sformatf("v%0d_done_cycle", i), dk, 9);
            chk($sformatf("v%0d_busy_cycles", i), bn, 8);
            chk($sformatf("v%0d_stim_seq", i), sb, 0);
            chk($sformatf("v%0d_done_pulses", i), dn, 1);
            chk($sformatf("v%0d_err", i), err2, tbl[i].exp_err);
            chk($sformatf("v%0d_fv", i), fv2, tbl[i].exp_fv);
            chk($sformatf("v%0d_fvec", i), fvec2, tbl[i].exp_fvec);
            chk($sformatf("v%0d_pass", i), pass2, tbl[i].exp_pass);
            chk($sformatf("v%0d_stim_hold", i), stim2, 3);
        end

        // Abort mid-sweep with reset while stim is 10
        rsel2 = 1;
        @(negedge clk);
        mode2 = 3'd0; start2 = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start2 = 1'b0;
        waited = 0;
        while (stim2 !== 2'b10 && waited < 20) begin
            @(negedge clk);
            waited++;
        end
        chk("abort_reached_10", stim2, 2);
        chk("abort_err_before", err2, 1);
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        chk("abort_busy", busy2, 0);
        chk("abort_stim", stim2, 0);
        chk("abort_err", err2, 0);
        chk("abort_fv", fv2, 0);
        dn = done2;
        repeat (4) begin
            @(negedge clk);
            dn += done2;
        end
        chk("abort_no_done", dn, 0);

        rsel2 = 0;
        run2(3'd0, 3, dk, bn, sb, dn);
        chk("restart_done_cycle", dk, 9);
        chk("restart_busy_cycles", bn, 8);
        chk("restart_stim_seq", sb, 0);
        chk("restart_done_pulses", dn, 1);
        chk("restart_pass", pass2, 1);

        // 3-input NAND, one cycle per vector
        @(negedge clk);
        mode3 = 3'd3; start3 = 1'b1;
        @(posedge clk);
        dk = 0; bn = 0; sb = 0; dn = 0;
        for (int k = 1; k <= 14; k++) begin
            @(negedge clk);
            start3 = 1'b0;
            if (busy3) begin
                bn++;
                if (k > 8 || stim3 !== 3'(k - 1)) sb++;
            end
            if (done3) begin
                dn++;
                if (dk == 0) dk = k;
            end
        end
        chk("w3_done_cycle", dk, 9);
        chk("w3_busy_cycles", bn, 8);
        chk("w3_stim_seq", sb, 0);
        chk("w3_done_pulses", dn, 1);
        chk("w3_pass", pass3, 1);
        chk("w3_err", err3, 0);
        chk("w3_fv", fv3, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
